// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation valve scheduler: FSM state codes,
// default divider widths and run lengths.
package rega_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t GOT_RUN = 2'd1;
  localparam state_t ASP_RUN = 2'd2;
  localparam state_t PAUSE   = 2'd3;

  localparam int DEF_SEL_LOG2  = 16;
  localparam int DEF_GOT_LOG2  = 21;
  localparam int DEF_ASP_LOG2  = 24;
  localparam int DEF_GOT_TICKS = 8;
  localparam int DEF_ASP_TICKS = 4;

  // Run counter width covers the full 1..255 tick range.
  localparam int RUN_W = 8;

endpackage

// File: rtl/rega_tick_gen.sv
// Free-running synchronous divider producing the display, drip and sprinkler
// tick strobes plus the display multiplex select.
module rega_tick_gen
  import rega_pkg::*;
#(
  parameter int SEL_LOG2 = DEF_SEL_LOG2,
  parameter int GOT_LOG2 = DEF_GOT_LOG2,
  parameter int ASP_LOG2 = DEF_ASP_LOG2
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick_sel,
  output logic tick_got,
  output logic tick_asp,
  output logic sel
);

  logic [ASP_LOG2-1:0] cnt_q;
  logic [ASP_LOG2-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + ASP_LOG2'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Each strobe fires on the last count of its power-of-two period.
  assign tick_sel = &cnt_q[SEL_LOG2-1:0];
  assign tick_got = &cnt_q[GOT_LOG2-1:0];
  assign tick_asp = &cnt_q;
  assign sel      = cnt_q[SEL_LOG2-1];

endmodule

// File: rtl/rega_scheduler.sv
// Shares one water supply between the drip and sprinkler valves: round-robin
// grant, fixed-length runs, dead time between valves, tank-low cut-off.
module rega_scheduler
  import rega_pkg::*;
#(
  parameter int SEL_LOG2  = DEF_SEL_LOG2,
  parameter int GOT_LOG2  = DEF_GOT_LOG2,
  parameter int ASP_LOG2  = DEF_ASP_LOG2,
  parameter int GOT_TICKS = DEF_GOT_TICKS,
  parameter int ASP_TICKS = DEF_ASP_TICKS
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req_got,
  input  logic req_asp,
  input  logic tank_low,
  output logic valve_got,
  output logic valve_asp,
  output logic busy,
  output logic alarm,
  output logic sel
);

  localparam logic [RUN_W-1:0] GOT_END = RUN_W'(GOT_TICKS);
  localparam logic [RUN_W-1:0] ASP_END = RUN_W'(ASP_TICKS);

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] run_inc_s;
  logic             last_asp_q, last_asp_d;
  logic             valve_got_q, valve_got_d;
  logic             valve_asp_q, valve_asp_d;
  logic             alarm_q, alarm_d;
  logic             tick_sel_s, tick_got_s, tick_asp_s;

  rega_tick_gen #(
    .SEL_LOG2 (SEL_LOG2),
    .GOT_LOG2 (GOT_LOG2),
    .ASP_LOG2 (ASP_LOG2)
  ) u_tick_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .tick_sel (tick_sel_s),
    .tick_got (tick_got_s),
    .tick_asp (tick_asp_s),
    .sel      (sel)
  );

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    last_asp_d = last_asp_q;
    run_inc_s  = run_q + RUN_W'(1);
    alarm_d    = tank_low;
    // Tank-low abort wins over everything and leaves the round-robin pointer alone.
    if (tank_low) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_got && (!req_asp || last_asp_q)) begin
            state_d    = GOT_RUN;
            run_d      = '0;
            last_asp_d = 1'b0;
          end else if (req_asp) begin
            state_d    = ASP_RUN;
            run_d      = '0;
            last_asp_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        GOT_RUN: begin
          if (!req_got) begin
            state_d = PAUSE;
          end else if (tick_got_s) begin
            run_d   = run_inc_s;
            state_d = (run_inc_s == GOT_END) ? PAUSE : GOT_RUN;
          end else begin
            state_d = GOT_RUN;
          end
        end
        ASP_RUN: begin
          if (!req_asp) begin
            state_d = PAUSE;
          end else if (tick_asp_s) begin
            run_d   = run_inc_s;
            state_d = (run_inc_s == ASP_END) ? PAUSE : ASP_RUN;
          end else begin
            state_d = ASP_RUN;
          end
        end
        PAUSE: begin
          if (tick_sel_s) begin
            state_d = IDLE;
          end else begin
            state_d = PAUSE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    valve_got_d = (state_d == GOT_RUN);
    valve_asp_d = (state_d == ASP_RUN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      run_q       <= '0;
      last_asp_q  <= 1'b1;
      valve_got_q <= 1'b0;
      valve_asp_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      last_asp_q  <= last_asp_d;
      valve_got_q <= valve_got_d;
      valve_asp_q <= valve_asp_d;
      alarm_q     <= alarm_d;
    end
  end

  assign valve_got = valve_got_q;
  assign valve_asp = valve_asp_q;
  assign alarm     = alarm_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rega_scheduler.sv
// Self-checking bench for rega_scheduler with small divider widths; a
// behavioural model tracks the expected outputs every cycle.
module tb_rega_scheduler;

  localparam int SEL_P = 4;
  localparam int GOT_P = 8;
  localparam int ASP_P = 16;
  localparam int GT    = 2;
  localparam int AT    = 2;

  logic clock    = 1'b0;
  logic reset_n  = 1'b0;
  logic req_got  = 1'b0;
  logic req_asp  = 1'b0;
  logic tank_low = 1'b0;
  logic valve_got, valve_asp, busy, alarm, sel;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which valve is open (0 none, 1 drip, 2 sprinkler), dead time flag,
  // ticks consumed, round-robin memory, alarm and the clock count since reset.
  int m_cnt, m_run, m_ticks;
  bit m_pause, m_last_asp, m_alarm;

  always #5 clock = ~clock;

  rega_scheduler #(
    .SEL_LOG2  (2),
    .GOT_LOG2  (3),
    .ASP_LOG2  (4),
    .GOT_TICKS (GT),
    .ASP_TICKS (AT)
  ) u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_got   (req_got),
    .req_asp   (req_asp),
    .tank_low  (tank_low),
    .valve_got (valve_got),
    .valve_asp (valve_asp),
    .busy      (busy),
    .alarm     (alarm),
    .sel       (sel)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    m_cnt = 0; m_run = 0; m_ticks = 0;
    m_pause = 1'b0; m_last_asp = 1'b1; m_alarm = 1'b0;
  endtask

  task automatic model_step();
    bit ts, tg, ta, still_req, tick_hit;
    int limit;
    ts = (m_cnt % SEL_P) == SEL_P - 1;
    tg = (m_cnt % GOT_P) == GOT_P - 1;
    ta = (m_cnt % ASP_P) == ASP_P - 1;
    if (tank_low) begin
      m_run = 0;
      m_pause = 1'b0;
    end else if (m_run != 0) begin
      still_req = (m_run == 1) ? req_got : req_asp;
      tick_hit  = (m_run == 1) ? tg : ta;
      limit     = (m_run == 1) ? GT : AT;
      if (!still_req) begin
        m_run = 0; m_pause = 1'b1;
      end else if (tick_hit) begin
        m_ticks++;
        if (m_ticks >= limit) begin
          m_run = 0; m_pause = 1'b1;
        end
      end
    end else if (m_pause) begin
      if (ts) m_pause = 1'b0;
    end else begin
      if (req_got && req_asp) m_run = m_last_asp ? 1 : 2;
      else if (req_got)       m_run = 1;
      else if (req_asp)       m_run = 2;
      if (m_run != 0) begin
        m_ticks = 0;
        m_last_asp = (m_run == 2);
      end
    end
    m_alarm = tank_low;
    m_cnt = (m_cnt + 1) % ASP_P;
  endtask

  task automatic compare_all();
    chk("valve_got", valve_got, m_run == 1);
    chk("valve_asp", valve_asp, m_run == 2);
    chk("busy", busy, (m_run != 0) || m_pause);
    chk("alarm", alarm, m_alarm);
    chk("sel", sel, (m_cnt / 2) % 2);
    chk("tick_sel", u_dut.tick_sel_s, (m_cnt % SEL_P) == SEL_P - 1);
    chk("tick_got", u_dut.tick_got_s, (m_cnt % GOT_P) == GOT_P - 1);
    chk("tick_asp", u_dut.tick_asp_s, (m_cnt % ASP_P) == ASP_P - 1);
    chk("exclusive", valve_got & valve_asp, 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_got = 1'b0; req_asp = 1'b0; tank_low = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    model_init();
    chk("rst_valve_got", valve_got, 0);
    chk("rst_valve_asp", valve_asp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_sel", sel, 0);
  endtask

  initial begin
    int hi, n_ts, n_tg, n_ta, n_tog;
    bit pg, pa, ps;
    int order[$];

    // Single drip run: high after edges 1..15, dead time ends at edge 20.
    do_reset();
    req_got = 1'b1;
    hi = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (valve_got) hi++;
      if (k == 15) chk("drip_last_high", valve_got, 1);
      if (k == 16) chk("drip_dropped", valve_got, 0);
      if (k == 20) chk("drip_idle_after_pause", busy, 0);
    end
    chk("drip_length", hi, 15);
    req_got = 1'b0;
    cycle();

    // Tie: grants alternate drip, sprinkler, drip.
    do_reset();
    req_got = 1'b1; req_asp = 1'b1;
    pg = 1'b0; pa = 1'b0;
    for (int k = 0; k < 120; k++) begin
      cycle();
      if (valve_got && !pg) order.push_back(1);
      if (valve_asp && !pa) order.push_back(2);
      pg = valve_got; pa = valve_asp;
    end
    chk("tie_grants", order.size() >= 3, 1);
    chk("tie_first", order[0], 1);
    chk("tie_second", order[1], 2);
    chk("tie_third", order[2], 1);

    // Sprinkler request dropped three cycles into the run.
    do_reset();
    req_asp = 1'b1;
    for (int i = 0; i < 40 && !valve_asp; i++) cycle();
    chk("drop_granted", valve_asp, 1);
    cycle(); cycle(); cycle();
    req_asp = 1'b0;
    cycle();
    chk("drop_valve_off", valve_asp, 0);
    chk("drop_in_pause", busy, 1);

    // Tank low during a drip run, then a tie goes to the sprinkler.
    do_reset();
    req_got = 1'b1;
    cycle(); cycle(); cycle();
    tank_low = 1'b1;
    cycle();
    chk("tank_valve_off", valve_got, 0);
    chk("tank_idle", busy, 0);
    chk("tank_alarm", alarm, 1);
    tank_low = 1'b0; req_asp = 1'b1;
    cycle();
    chk("tank_tie_to_asp", valve_asp, 1);
    chk("tank_alarm_clear", alarm, 0);

    // Asynchronous reset in the middle of a sprinkler run.
    do_reset();
    req_asp = 1'b1;
    cycle(); cycle(); cycle();
    chk("rstmid_running", valve_asp, 1);
    chk("rstmid_sel_before", sel, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rstmid_valve_off", valve_asp, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_sel", sel, 0);
    req_asp = 1'b0;
    @(posedge clock);
    #1;

    // Divider: 32 idle cycles.
    do_reset();
    n_ts = 0; n_tg = 0; n_ta = 0; n_tog = 0;
    ps = sel;
    for (int k = 0; k < 32; k++) begin
      cycle();
      if (u_dut.tick_sel_s) n_ts++;
      if (u_dut.tick_got_s) n_tg++;
      if (u_dut.tick_asp_s) n_ta++;
      if (sel != ps) n_tog++;
      ps = sel;
    end
    chk("div_tick_sel", n_ts, 8);
    chk("div_tick_got", n_tg, 4);
    chk("div_tick_asp", n_ta, 2);
    chk("div_sel_toggles", n_tog, 16);

    // Random traffic with occasional tank-low pulses.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) req_got = ~req_got;
      if ($urandom_range(0, 15) == 0) req_asp = ~req_asp;
      tank_low = ($urandom_range(0, 63) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
